// File: rtl/semaforo_sched_pkg.sv
// Shared phase and lamp encodings, default durations and green-duration helper
// for the traffic-light scheduler.
package semaforo_sched_pkg;

  typedef enum logic [2:0] {
    PhAllredA  = 3'd0,
    PhNsGreen  = 3'd1,
    PhNsYellow = 3'd2,
    PhAllredB  = 3'd3,
    PhEwGreen  = 3'd4,
    PhEwYellow = 3'd5,
    PhPedWalk  = 3'd6
  } phase_e;

  localparam logic [2:0] LampRed = 3'b100;
  localparam logic [2:0] LampYel = 3'b010;
  localparam logic [2:0] LampGrn = 3'b001;

  localparam int unsigned GreenMinDef = 5;
  localparam int unsigned YellowTDef  = 3;
  localparam int unsigned AllredTDef  = 1;
  localparam int unsigned PedTDef     = 8;

  localparam int unsigned CntW = 6;

  // Green lasts max(switch field, minimum green).
  function automatic logic [CntW-1:0] green_dur(input logic [4:0] field,
                                                input int unsigned gmin);
    logic [CntW-1:0] f;
    logic [CntW-1:0] m;
    f = {1'b0, field};
    m = CntW'(gmin);
    return (f > m) ? f : m;
  endfunction

endpackage

// File: rtl/semaforo_sched_if.sv
// Handshake bundle between the scheduler and its environment; signal names are
// seen from the scheduler side (i_ into it, o_ out of it).
interface semaforo_sched_if;

  logic       i_tick;
  logic [9:0] i_sw;
  logic       i_ped_req;
  logic [2:0] o_ns_light;
  logic [2:0] o_ew_light;
  logic       o_walk;
  logic       o_ped_ack;
  logic [2:0] o_state;
  logic [5:0] o_remaining;

  modport slave (
    input  i_tick,
    input  i_sw,
    input  i_ped_req,
    output o_ns_light,
    output o_ew_light,
    output o_walk,
    output o_ped_ack,
    output o_state,
    output o_remaining
  );

  modport master (
    output i_tick,
    output i_sw,
    output i_ped_req,
    input  o_ns_light,
    input  o_ew_light,
    input  o_walk,
    input  o_ped_ack,
    input  o_state,
    input  o_remaining
  );

endinterface

// File: rtl/semaforo_sched_phase_timer.sv
// Phase duration counter: loadable down-counter stepped by tick, expiring on the
// tick that would take it from 1 to 0.
module semaforo_sched_phase_timer #(
  parameter int unsigned     WIDTH     = 6,
  parameter logic [WIDTH-1:0] RESET_VAL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_tick,
  output logic [WIDTH-1:0] o_count,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;

  // Load wins over decrement so the expiring edge starts the next phase cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= RESET_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_expire = i_tick && (r_count == WIDTH'(1));

endmodule

// File: rtl/semaforo_sched.sv
// Traffic-light phase scheduler: NS/EW ring with all-red clearance and an
// optional pedestrian walk slotted in after either all-red phase.
module semaforo_sched
  import semaforo_sched_pkg::*;
#(
  parameter int unsigned GREEN_MIN = GreenMinDef,
  parameter int unsigned YELLOW_T  = YellowTDef,
  parameter int unsigned ALLRED_T  = AllredTDef,
  parameter int unsigned PED_T     = PedTDef
) (
  input logic             clk,
  input logic             rst_n,
  semaforo_sched_if.slave bus
);

  localparam logic [CntW-1:0] YellowDur = CntW'(YELLOW_T);
  localparam logic [CntW-1:0] AllredDur = CntW'(ALLRED_T);
  localparam logic [CntW-1:0] PedDur    = CntW'(PED_T);

  phase_e          r_state;
  phase_e          w_state_d;
  logic            r_ped_pending;
  logic            w_ped_pending_d;
  logic            r_walk_to_ew;
  logic            w_walk_to_ew_d;
  logic            w_enter_walk;
  logic [2:0]      r_ns_light;
  logic [2:0]      r_ew_light;
  logic            r_walk;
  logic [2:0]      w_ns_light_d;
  logic [2:0]      w_ew_light_d;
  logic            w_walk_d;
  logic [CntW-1:0] w_load_val;
  logic [CntW-1:0] w_remaining;
  logic            w_expire;

  semaforo_sched_phase_timer #(
    .WIDTH    (CntW),
    .RESET_VAL(AllredDur)
  ) u_phase_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_expire),
    .i_load_val(w_load_val),
    .i_tick    (bus.i_tick),
    .o_count   (w_remaining),
    .o_expire  (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= PhAllredA;
      r_ped_pending <= 1'b0;
      r_walk_to_ew  <= 1'b0;
      r_ns_light    <= LampRed;
      r_ew_light    <= LampRed;
      r_walk        <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_ped_pending <= w_ped_pending_d;
      r_walk_to_ew  <= w_walk_to_ew_d;
      r_ns_light    <= w_ns_light_d;
      r_ew_light    <= w_ew_light_d;
      r_walk        <= w_walk_d;
    end
  end

  // r_walk_to_ew remembers which green the walk phase hands over to.
  always_comb begin
    w_state_d      = r_state;
    w_walk_to_ew_d = r_walk_to_ew;
    if (w_expire) begin
      unique case (r_state)
        PhAllredA: begin
          if (r_ped_pending) begin
            w_state_d      = PhPedWalk;
            w_walk_to_ew_d = 1'b0;
          end else begin
            w_state_d = PhNsGreen;
          end
        end
        PhNsGreen:  w_state_d = PhNsYellow;
        PhNsYellow: w_state_d = PhAllredB;
        PhAllredB: begin
          if (r_ped_pending) begin
            w_state_d      = PhPedWalk;
            w_walk_to_ew_d = 1'b1;
          end else begin
            w_state_d = PhEwGreen;
          end
        end
        PhEwGreen:  w_state_d = PhEwYellow;
        PhEwYellow: w_state_d = PhAllredA;
        PhPedWalk:  w_state_d = r_walk_to_ew ? PhEwGreen : PhNsGreen;
        default:    w_state_d = PhAllredA;
      endcase
    end

    // Entering walk clears the request even if the button is still pressed.
    w_enter_walk = (w_state_d == PhPedWalk) && (r_state != PhPedWalk);
    if (w_enter_walk) begin
      w_ped_pending_d = 1'b0;
    end else if (bus.i_ped_req && (r_state != PhPedWalk)) begin
      w_ped_pending_d = 1'b1;
    end else begin
      w_ped_pending_d = r_ped_pending;
    end
  end

  // Lamps and the timer reload are decoded from the upcoming phase so both
  // land in registers on the same edge that enters it.
  always_comb begin
    w_ns_light_d = LampRed;
    w_ew_light_d = LampRed;
    w_walk_d     = 1'b0;
    w_load_val   = AllredDur;
    unique case (w_state_d)
      PhNsGreen: begin
        w_ns_light_d = LampGrn;
        w_load_val   = green_dur(bus.i_sw[4:0], GREEN_MIN);
      end
      PhNsYellow: begin
        w_ns_light_d = LampYel;
        w_load_val   = YellowDur;
      end
      PhEwGreen: begin
        w_ew_light_d = LampGrn;
        w_load_val   = green_dur(bus.i_sw[9:5], GREEN_MIN);
      end
      PhEwYellow: begin
        w_ew_light_d = LampYel;
        w_load_val   = YellowDur;
      end
      PhPedWalk: begin
        w_walk_d   = 1'b1;
        w_load_val = PedDur;
      end
      default: begin
        w_load_val = AllredDur;
      end
    endcase
  end

  assign bus.o_state     = r_state;
  assign bus.o_remaining = w_remaining;
  assign bus.o_ns_light  = r_ns_light;
  assign bus.o_ew_light  = r_ew_light;
  assign bus.o_walk      = r_walk;
  assign bus.o_ped_ack   = r_ped_pending;

endmodule
